// File: rtl/menu_select_ctrl.sv
// Menu selection controller: tracks the selected row of a vertical button menu from
// key levels and emits registered per-pixel tile position and button type.
module menu_select_ctrl #(
  parameter int NUM_BUTTONS = 4,
  parameter int MENU_X      = 260,
  parameter int MENU_Y      = 100,
  parameter int TILE_W      = 128,
  parameter int TILE_H      = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        keyEnter,
  output logic [10:0] tileTopLeftX,
  output logic [10:0] tileTopLeftY,
  output logic [2:0]  button_type,
  output logic [2:0]  selectedIdx,
  output logic        confirmPulse,
  output logic        menuActive
);

  typedef enum logic [1:0] {IDLE, BROWSE, LOCKED} state_t;

  localparam logic [2:0] BTN_FREE = 3'b000;
  localparam logic [2:0] BTN_REGU = 3'b001;
  localparam logic [2:0] BTN_SLCT = 3'b010;
  localparam logic [2:0] SEL_MAX  = 3'(NUM_BUTTONS - 1);

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        pend_up_q, pend_up_d;
  logic        pend_dn_q, pend_dn_d;
  logic [2:0]  key_prev_q;
  logic [2:0]  keys, key_edge;
  logic        confirm_q, confirm_d;
  logic        active_q;
  logic [10:0] tile_x_q, tile_x_d;
  logic [10:0] tile_y_q, tile_y_d;
  logic [2:0]  type_q, type_d;

  assign keys     = {keyEnter, keyDown, keyUp};
  assign key_edge = keys & ~key_prev_q;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    logic up_any, dn_any;
    state_d   = state_q;
    sel_d     = sel_q;
    pend_up_d = pend_up_q;
    pend_dn_d = pend_dn_q;
    confirm_d = 1'b0;
    up_any    = pend_up_q | key_edge[0];
    dn_any    = pend_dn_q | key_edge[1];
    if (!enable) begin
      state_d   = IDLE;
      sel_d     = '0;
      pend_up_d = 1'b0;
      pend_dn_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sel_d     = '0;
          pend_up_d = 1'b0;
          pend_dn_d = 1'b0;
          if (startOfFrame) state_d = BROWSE;
        end
        BROWSE: begin
          if (key_edge[2]) begin
            // Enter wins over any move seen in the same cycle.
            confirm_d = 1'b1;
            state_d   = LOCKED;
            pend_up_d = 1'b0;
            pend_dn_d = 1'b0;
          end else if (startOfFrame) begin
            if (up_any && !dn_any)
              sel_d = (sel_q == 3'd0) ? SEL_MAX : sel_q - 3'd1;
            else if (dn_any && !up_any)
              sel_d = (sel_q == SEL_MAX) ? 3'd0 : sel_q + 3'd1;
            pend_up_d = 1'b0;
            pend_dn_d = 1'b0;
          end else begin
            pend_up_d = up_any;
            pend_dn_d = dn_any;
          end
        end
        LOCKED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Parallel row comparators; selection and state are taken as they stand this cycle.
  always_comb begin
    logic        in_col;
    logic [11:0] lo, hi;
    tile_x_d = '0;
    tile_y_d = '0;
    type_d   = BTN_FREE;
    lo       = '0;
    hi       = '0;
    in_col   = ({1'b0, pixelX} >= 12'(MENU_X)) && ({1'b0, pixelX} < 12'(MENU_X + TILE_W));
    if (enable && state_q != IDLE && in_col) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        lo = 12'(MENU_Y + i * TILE_H);
        hi = 12'(MENU_Y + (i + 1) * TILE_H);
        if ({1'b0, pixelY} >= lo && {1'b0, pixelY} < hi) begin
          tile_x_d = 11'(MENU_X);
          tile_y_d = lo[10:0];
          type_d   = (3'(i) == sel_q) ? BTN_SLCT : BTN_REGU;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      pend_up_q  <= 1'b0;
      pend_dn_q  <= 1'b0;
      key_prev_q <= 3'b111;  // a key held through reset must not look like a press
      confirm_q  <= 1'b0;
      active_q   <= 1'b0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      type_q     <= BTN_FREE;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      key_prev_q <= keys;
      confirm_q  <= confirm_d;
      active_q   <= (state_d != IDLE);
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      type_q     <= type_d;
    end
  end

  assign tileTopLeftX = tile_x_q;
  assign tileTopLeftY = tile_y_q;
  assign button_type  = type_q;
  assign selectedIdx  = sel_q;
  assign confirmPulse = confirm_q;
  assign menuActive   = active_q;

endmodule

// File: tb/tb_menu_select_ctrl.sv
// Directed bench for menu_select_ctrl with default parameters (4 rows at 260,100, 128x64 tiles).
module tb_menu_select_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, enable, keyUp, keyDown, keyEnter;
  logic [10:0] tileTopLeftX, tileTopLeftY;
  logic [2:0]  button_type, selectedIdx;
  logic        confirmPulse, menuActive;

  int checks = 0;
  int errors = 0;

  menu_select_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .keyUp        (keyUp),
    .keyDown      (keyDown),
    .keyEnter     (keyEnter),
    .tileTopLeftX (tileTopLeftX),
    .tileTopLeftY (tileTopLeftY),
    .button_type  (button_type),
    .selectedIdx  (selectedIdx),
    .confirmPulse (confirmPulse),
    .menuActive   (menuActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic press_down();
    keyDown = 1'b1; tick();
    keyDown = 1'b0; tick();
  endtask

  task automatic press_up();
    keyUp = 1'b1; tick();
    keyUp = 1'b0; tick();
  endtask

  task automatic tile(input string tag, input int x, input int y,
                      input int ex, input int ey, input int et);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    check({tag, "_x"}, 32'(tileTopLeftX), 32'(ex));
    check({tag, "_y"}, 32'(tileTopLeftY), 32'(ey));
    check({tag, "_t"}, 32'(button_type), 32'(et));
  endtask

  initial begin
    resetN = 1'b0; pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
    enable = 1'b0; keyUp = 1'b0; keyDown = 1'b1; keyEnter = 1'b0;
    tick(3);
    check("rst_active", 32'(menuActive), 0);
    check("rst_sel", 32'(selectedIdx), 0);
    check("rst_confirm", 32'(confirmPulse), 0);
    check("rst_type", 32'(button_type), 0);
    check("rst_x", 32'(tileTopLeftX), 0);
    resetN = 1'b1;
    tick();

    // keyDown held through reset: entering BROWSE must not step.
    enable = 1'b1;
    frame();
    check("enter_active", 32'(menuActive), 1);
    tick(3);
    frame();
    check("held_no_step", 32'(selectedIdx), 0);
    keyDown = 1'b0;
    tick();

    press_down(); frame();
    check("down1", 32'(selectedIdx), 1);
    press_down(); frame();
    press_down(); frame();
    check("down3", 32'(selectedIdx), 3);
    press_down(); frame();
    check("wrap_down", 32'(selectedIdx), 0);
    press_up(); frame();
    check("wrap_up", 32'(selectedIdx), 3);

    // Three presses in one frame: single step, nothing visible until the frame edge.
    press_down(); press_down(); press_down();
    check("no_tear", 32'(selectedIdx), 3);
    frame();
    check("multi_press", 32'(selectedIdx), 0);
    press_up(); press_down(); frame();
    check("up_and_down", 32'(selectedIdx), 0);

    // Edge coinciding with startOfFrame counts in that update.
    keyDown = 1'b1; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0; keyDown = 1'b0;
    check("edge_at_sof", 32'(selectedIdx), 1);
    tick();

    tile("p300_170", 300, 170, 260, 164, 2);
    tile("p300_120", 300, 120, 260, 100, 1);
    tile("p200_120", 200, 120, 0, 0, 0);
    tile("right_in", 387, 100, 260, 100, 1);
    tile("right_out", 388, 100, 0, 0, 0);
    tile("left_in", 260, 355, 260, 292, 1);
    tile("bottom_out", 300, 356, 0, 0, 0);
    tile("top_out", 300, 99, 0, 0, 0);

    press_down(); frame();
    check("sel2", 32'(selectedIdx), 2);

    keyEnter = 1'b1;
    tick();
    check("confirm_hi", 32'(confirmPulse), 1);
    tick();
    check("confirm_lo", 32'(confirmPulse), 0);
    check("locked_active", 32'(menuActive), 1);
    keyEnter = 1'b0;
    tick();
    press_down(); press_up(); press_down(); frame();
    check("locked_frozen", 32'(selectedIdx), 2);
    keyEnter = 1'b1; tick();
    check("locked_no_confirm", 32'(confirmPulse), 0);
    keyEnter = 1'b0;
    tile("locked_row2", 300, 240, 260, 228, 2);

    // Drop enable mid-frame while the pixel is inside the menu.
    enable = 1'b0;
    tick();
    check("drop_active", 32'(menuActive), 0);
    check("drop_sel", 32'(selectedIdx), 0);
    check("drop_type", 32'(button_type), 0);
    check("drop_y", 32'(tileTopLeftY), 0);
    tile("idle_tile", 300, 170, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle.
    enable = 1'b1;
    frame();
    press_down(); frame();
    check("pre_reset_sel", 32'(selectedIdx), 1);
    pixelX = 11'd300; pixelY = 11'd170;
    tick();
    check("pre_reset_type", 32'(button_type), 2);
    #3 resetN = 1'b0;
    #1;
    check("async_active", 32'(menuActive), 0);
    check("async_sel", 32'(selectedIdx), 0);
    check("async_type", 32'(button_type), 0);
    check("async_x", 32'(tileTopLeftX), 0);
    tick();
    resetN = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
